addsub_share_arbiter: RTL and testbench

- Round-robin arbiter and 2-stage pipeline sharing one signed saturating add/sub datapath among NUM_REQ requesters (ALU ports, address generator, DSP microcode) in the custom CPU.
- Accepts at most one operation per cycle via per-requester valid/ready, then returns a registered result tagged with the requester ID on a single response port with back-pressure.

---
 rtl/addsub_share_arbiter.sv | 137 +++++++++++++
 tb/tb_addsub_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_share_arbiter.sv
// ============================================================================
// Module   : addsub_share_arbiter
// Purpose  : Round-robin arbiter feeding a shared 2-stage signed saturating
//            add/sub pipeline with ID-tagged, back-pressured responses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module addsub_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ID_W    = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_REQ-1:0]        req_valid_in,
    input  logic [NUM_REQ-1:0]        req_op_in,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_in,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_in,
    output logic [NUM_REQ-1:0]        req_ready_out,
    output logic                      resp_valid_out,
    input  logic                      resp_ready_in,
    output logic [ID_W-1:0]           resp_id_out,
    output logic [DATA_W-1:0]         resp_data_out,
    output logic                      resp_sat_out
);

    localparam logic [DATA_W-1:0] c_max_pos = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_min_neg = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ID_W-1:0]   c_last_id = ID_W'(NUM_REQ - 1);

    if ((ID_W != $clog2(NUM_REQ)) || (NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_params
        $error("addsub_share_arbiter: NUM_REQ must be 2..8 and ID_W == clog2(NUM_REQ)");
    end

    logic [ID_W-1:0]   r_ptr;
    logic              r_s1_valid;
    logic              r_s1_op;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic [ID_W-1:0]   r_s1_id;

    logic              w_any;
    logic [ID_W-1:0]   w_win;
    logic              w_adv;
    logic              w_acc;
    logic              w_s2_load;
    logic [DATA_W-1:0] w_bx;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_res;
    logic              w_sat;

    // Search upward from the pointer; iterating downward lets the closest hit win.
    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid_in[idx]) begin
                w_any = 1'b1;
                w_win = idx[ID_W-1:0];
            end
        end
    end

    // Stage 1 may refill whenever it is empty or will hand its op to stage 2.
    assign w_adv     = !r_s1_valid || !resp_valid_out || resp_ready_in;
    assign w_acc     = w_any && w_adv;
    assign w_s2_load = r_s1_valid && (!resp_valid_out || resp_ready_in);

    always_comb begin
        req_ready_out = '0;
        if (w_acc) begin
            req_ready_out = NUM_REQ'(1) << w_win;
        end
    end

    // SUB is a + ~b + 1; one guard bit exposes overflow in either direction.
    assign w_bx  = r_s1_b ^ {DATA_W{r_s1_op}};
    assign w_sum = {r_s1_a[DATA_W-1], r_s1_a} + {w_bx[DATA_W-1], w_bx} + (DATA_W+1)'(r_s1_op);

    always_comb begin
        w_res = w_sum[DATA_W-1:0];
        w_sat = 1'b0;
        if (!w_sum[DATA_W] && w_sum[DATA_W-1]) begin
            w_res = c_max_pos;
            w_sat = 1'b1;
        end else if (w_sum[DATA_W] && !w_sum[DATA_W-1]) begin
            w_res = c_min_neg;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_op    <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_acc;
            if (w_acc) begin
                r_s1_op <= req_op_in[w_win];
                r_s1_a  <= req_a_in[w_win*DATA_W +: DATA_W];
                r_s1_b  <= req_b_in[w_win*DATA_W +: DATA_W];
                r_s1_id <= w_win;
                r_ptr   <= (w_win == c_last_id) ? '0 : w_win + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            resp_valid_out <= 1'b0;
            resp_id_out    <= '0;
            resp_data_out  <= '0;
            resp_sat_out   <= 1'b0;
        end else if (w_s2_load) begin
            resp_valid_out <= 1'b1;
            resp_id_out    <= r_s1_id;
            resp_data_out  <= w_res;
            resp_sat_out   <= w_sat;
        end else if (resp_ready_in) begin
            resp_valid_out <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_addsub_share_arbiter.sv
// ============================================================================
// Module   : tb_addsub_share_arbiter
// Purpose  : Scoreboard bench for addsub_share_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_addsub_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_op = '0;
    logic [NUM_REQ*DATA_W-1:0] req_a = '0;
    logic [NUM_REQ*DATA_W-1:0] req_b = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      resp_valid;
    logic                      resp_ready = 1'b1;
    logic [ID_W-1:0]           resp_id;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_sat;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_pop    = 0;
    logic [31:0] sb[$];
    int          grant_log[$];

    addsub_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .req_valid_in  (req_valid),
        .req_op_in     (req_op),
        .req_a_in      (req_a),
        .req_b_in      (req_b),
        .req_ready_out (req_ready),
        .resp_valid_out(resp_valid),
        .resp_ready_in (resp_ready),
        .resp_id_out   (resp_id),
        .resp_data_out (resp_data),
        .resp_sat_out  (resp_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result with plain integer arithmetic and explicit clamping.
    function automatic logic [31:0] model(input int id, input logic op, input logic [15:0] a,
                                          input logic [15:0] b);
        int   r;
        logic s;
        r = op ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        return {13'b0, id[1:0], s, r[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back(model(i, req_op[i], req_a[i*DATA_W +: DATA_W], req_b[i*DATA_W +: DATA_W]));
                    grant_log.push_back(i);
                    n_acc++;
                end
            end
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (resp_valid && resp_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    check("unexpected_resp", {13'b0, resp_id, resp_sat, resp_data}, 32'hFFFF_FFFF);
                end else begin
                    check("resp", {13'b0, resp_id, resp_sat, resp_data}, sb.pop_front());
                end
            end
        end
    end

    task automatic set_req(input int i, input logic op, input logic [15:0] a, input logic [15:0] b);
        req_op[i]               = op;
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'($urandom_range(1)), 16'($urandom), 16'($urandom));
        end
    endtask

    // Present one op and hold it until accepted, bounded.
    task automatic drive_one(input int i, input logic op, input logic [15:0] a, input logic [15:0] b);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        set_req(i, op, a, b);
        req_valid[i] = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (req_ready[i]) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        req_valid[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int wait_cnt, r1_grants, acc0, pop0;
        bit r1;
        logic [15:0] held_data;
        logic [1:0]  held_id;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id",    32'(resp_id),    32'd0);
        check("rst_resp_data",  32'(resp_data),  32'd0);
        check("rst_resp_sat",   32'(resp_sat),   32'd0);
        check("rst_ready",      32'(req_ready),  32'd0);
        rst = 1'b0;

        // Single ADD with latency check
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'd100, -16'sd30);
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("single_ready0", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("lat_t1_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_t2_valid", 32'(resp_valid), 32'd1);
        check("lat_t2_data",  32'(resp_data),  32'd70);
        check("lat_t2_id",    32'(resp_id),    32'd0);
        check("lat_t2_sat",   32'(resp_sat),   32'd0);
        idle(3);

        // Saturation corners (scoreboard compares each result)
        drive_one(1, 1'b0, 16'sd32767, 16'sd1);
        drive_one(2, 1'b1, 16'h8000,   16'sd1);
        drive_one(3, 1'b1, 16'sd0,     16'h8000);
        drive_one(3, 1'b1, 16'hFFFF,   16'h8000);
        idle(4);

        // Round-robin streaming, pointer is now 0
        grant_log.delete();
        randomize_ops();
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k >= 3) check("b2b_resp_valid", 32'(resp_valid), 32'd1);
            @(posedge clk); #1;
            randomize_ops();
        end
        req_valid = '0;
        check("rr_grant_count", 32'(grant_log.size()), 32'd12);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            check("rr_grant_order", 32'(grant_log[k]), 32'(k % 4));
        end
        idle(5);

        // Back-pressure
        resp_ready = 1'b0;
        acc0 = n_acc;
        randomize_ops();
        req_valid = 4'hF;
        idle(6);
        @(negedge clk);
        check("bp_accepts", 32'(n_acc - acc0), 32'd2);
        check("bp_ready_zero", 32'(req_ready), 32'd0);
        check("bp_resp_valid", 32'(resp_valid), 32'd1);
        held_data = resp_data;
        held_id   = resp_id;
        idle(3);
        check("bp_hold_data", 32'(resp_data), 32'(held_data));
        check("bp_hold_id",   32'(resp_id),   32'(held_id));
        acc0 = n_acc;
        pop0 = n_pop;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        idle(3);
        check("bp_pulse_pops", 32'(n_pop - pop0), 32'd1);
        check("bp_pulse_accepts", 32'(n_acc - acc0), 32'd1);
        req_valid  = '0;
        resp_ready = 1'b1;
        idle(5);

        // Fairness: req3 always valid, req1 drops for one cycle after each grant
        r1 = 1'b1;
        wait_cnt = 0;
        r1_grants = 0;
        req_valid = 4'b1010;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (r1) begin
                if (req_ready[1]) begin
                    check("fair_wait_le1", 32'(wait_cnt <= 1), 32'd1);
                    r1_grants++;
                    r1 = 1'b0;
                end else if (req_ready[3]) begin
                    wait_cnt++;
                end
            end else begin
                r1 = 1'b1;
                wait_cnt = 0;
            end
            @(posedge clk); #1;
            randomize_ops();
            req_valid = {1'b1, 1'b0, r1, 1'b0};
        end
        check("fair_r1_grants", 32'(r1_grants >= 10), 32'd1);
        req_valid = '0;
        idle(5);

        // Async reset with both stages full
        resp_ready = 1'b0;
        randomize_ops();
        req_valid = 4'hF;
        idle(5);
        check("pre_rst_full", 32'(resp_valid), 32'd1);
        @(negedge clk); #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("async_rst_valid", 32'(resp_valid), 32'd0);
        check("async_rst_data",  32'(resp_data),  32'd0);
        check("async_rst_id",    32'(resp_id),    32'd0);
        check("async_rst_sat",   32'(resp_sat),   32'd0);
        req_valid = 4'b1010;
        set_req(1, 1'b1, 16'd5, 16'd9);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;

        // Drain and confirm every expected response arrived
        for (int c = 0; c < 30 && sb.size() != 0; c++) @(posedge clk);
        idle(2);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
